// File: rtl/matrix_stream_pkg.sv
// Shared definitions for the matrix result streamer: FSM encoding and the
// flat-bus packing rule used by the multiplier, streamer and benches.
package matrix_stream_pkg;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = S_IDLE,
        ST_STREAM = S_STREAM,
        ST_DONE   = S_DONE
    } state_t;

    // Bit offset of element (r,c); element (0,0) occupies the top ELEM_W bits.
    function automatic int elem_lsb(input int r, input int c, input int rows,
                                    input int cols, input int elem_w);
        return (rows * cols - 1 - (r * cols + c)) * elem_w;
    endfunction

endpackage

// File: rtl/matrix_elem_mux.sv
// Combinational (row,col) element selector over a flattened ROWS x COLS matrix.
module matrix_elem_mux
    import matrix_stream_pkg::*;
#(
    parameter int ROWS   = 5,
    parameter int COLS   = 5,
    parameter int ELEM_W = 8,
    parameter int IDX_W  = 3
) (
    input  logic [ROWS*COLS*ELEM_W-1:0] mat,
    input  logic [IDX_W-1:0]            row,
    input  logic [IDX_W-1:0]            col,
    output logic [ELEM_W-1:0]           elem
);

    // NOTE: every output of an always_comb gets a default before any branch,
    // otherwise a coordinate with no match would infer a latch.
    always_comb begin
        elem = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (row == IDX_W'(r) && col == IDX_W'(c)) begin
                    elem = mat[elem_lsb(r, c, ROWS, COLS, ELEM_W) +: ELEM_W];
                end
            end
        end
    end

endmodule

// File: rtl/matrix_result_streamer.sv
// Captures a flat result matrix and streams it one element per valid/ready beat.
// Define COL_MAJOR_EN for column-major traversal (default is row-major).
module matrix_result_streamer
    import matrix_stream_pkg::*;
#(
    parameter  int ROWS    = 5,
    parameter  int COLS    = 5,
    parameter  int ELEM_W  = 8,
    localparam int MAT_LEN = ROWS * COLS * ELEM_W,
    localparam int MAX_DIM = (ROWS > COLS) ? ROWS : COLS,
    localparam int IDX_W   = ($clog2(MAX_DIM) > 1) ? $clog2(MAX_DIM) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [MAT_LEN-1:0] mat_in,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ELEM_W-1:0]  out_data,
    output logic [IDX_W-1:0]   out_row,
    output logic [IDX_W-1:0]   out_col,
    output logic               out_last,
    output logic               done
);

    state_t             state, state_nx;
    logic [MAT_LEN-1:0] shadow;
    logic [IDX_W-1:0]   row, col;
    logic               handshake, at_last, row_end, col_end;

    assign row_end   = (row == IDX_W'(ROWS - 1));
    assign col_end   = (col == IDX_W'(COLS - 1));
    assign at_last   = row_end && col_end;
    assign handshake = out_valid && out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        busy      = 1'b1;
        out_valid = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_nx = ST_STREAM;
            end
            ST_STREAM: begin
                out_valid = 1'b1;
                if (handshake && at_last) state_nx = ST_DONE;
            end
            ST_DONE: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: begin
                busy     = 1'b0;
                state_nx = ST_IDLE;
            end
        endcase
    end

    // NOTE: the shadow register is cleared on reset so out_data reads zero
    // before the first capture, not leftover contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow <= '0;
            row    <= '0;
            col    <= '0;
        end else if (state == ST_IDLE && start) begin
            shadow <= mat_in;
            row    <= '0;
            col    <= '0;
        end else if (handshake && !at_last) begin
`ifdef COL_MAJOR_EN
            if (row_end) begin
                row <= '0;
                col <= col + IDX_W'(1);
            end else begin
                row <= row + IDX_W'(1);
            end
`else
            if (col_end) begin
                col <= '0;
                row <= row + IDX_W'(1);
            end else begin
                col <= col + IDX_W'(1);
            end
`endif
        end
    end

    matrix_elem_mux #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .ELEM_W (ELEM_W),
        .IDX_W  (IDX_W)
    ) u_mux (
        .mat  (shadow),
        .row  (row),
        .col  (col),
        .elem (out_data)
    );

    assign out_row  = row;
    assign out_col  = col;
    assign out_last = out_valid && at_last;

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Self-checking bench for matrix_result_streamer: 5x5 instance plus a 1x1 instance.
module tb_matrix_result_streamer;

    localparam int ROWS    = 5;
    localparam int COLS    = 5;
    localparam int ELEM_W  = 8;
    localparam int MAT_LEN = ROWS * COLS * ELEM_W;
    localparam int IDX_W   = 3;

    logic               clk = 1'b0;
    logic               rst, start, out_ready;
    logic [MAT_LEN-1:0] mat_in, mat_ref;
    logic               busy, out_valid, out_last, done;
    logic [ELEM_W-1:0]  out_data;
    logic [IDX_W-1:0]   out_row, out_col;

    logic               start1, ready1;
    logic [ELEM_W-1:0]  mat1, data1;
    logic               busy1, valid1, last1, done1;
    logic [0:0]         row1, col1;

    always #5 clk = ~clk;

    matrix_result_streamer #(.ROWS(ROWS), .COLS(COLS), .ELEM_W(ELEM_W)) dut (
        .clk(clk), .rst(rst), .start(start), .mat_in(mat_in), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_col(out_col), .out_last(out_last), .done(done)
    );

    matrix_result_streamer #(.ROWS(1), .COLS(1), .ELEM_W(ELEM_W)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .mat_in(mat1), .busy(busy1),
        .out_valid(valid1), .out_ready(ready1), .out_data(data1),
        .out_row(row1), .out_col(col1), .out_last(last1), .done(done1)
    );

    typedef struct {
        logic [ELEM_W-1:0] data;
        logic [IDX_W-1:0]  row;
        logic [IDX_W-1:0]  col;
        logic              last;
    } beat_t;

    typedef struct {
        string      name;
        logic [3:0] pat;
        bit         mutate;
        bit         poke;
        int         exp_beats;
        int         exp_sum;
    } vec_t;

    beat_t exp_q[$];
    beat_t exp_b, prev_b;
    bit    prev_stall = 1'b0;
    int    beats = 0, sum = 0;
    int    errors = 0, checks = 0;
    vec_t  vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: pop one expected beat per handshake, and demand stable
    // outputs in the cycle after a stall.
    always @(negedge clk) begin
        if (out_valid) begin
            if (prev_stall) begin
                check("hold_data", 32'(out_data), 32'(prev_b.data));
                check("hold_row", 32'(out_row), 32'(prev_b.row));
                check("hold_col", 32'(out_col), 32'(prev_b.col));
            end
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    exp_b = exp_q.pop_front();
                    check("beat_data", 32'(out_data), 32'(exp_b.data));
                    check("beat_row", 32'(out_row), 32'(exp_b.row));
                    check("beat_col", 32'(out_col), 32'(exp_b.col));
                    check("beat_last", 32'(out_last), 32'(exp_b.last));
                end
                beats++;
                sum += int'(out_data);
            end
            prev_stall = !out_ready;
            prev_b     = '{data: out_data, row: out_row, col: out_col, last: out_last};
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic push_expected();
`ifdef COL_MAJOR_EN
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
                exp_q.push_back('{data: ELEM_W'(c + 1), row: IDX_W'(r), col: IDX_W'(c),
                                  last: (r == ROWS - 1 && c == COLS - 1)});
`else
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                exp_q.push_back('{data: ELEM_W'(c + 1), row: IDX_W'(r), col: IDX_W'(c),
                                  last: (r == ROWS - 1 && c == COLS - 1)});
`endif
    endtask

    task automatic run_stream(input vec_t v);
        int cyc;
        bit seen_done;
        beats = 0;
        sum   = 0;
        push_expected();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({v.name, "_first_valid"}, 32'(out_valid), 32'd1);
        check({v.name, "_busy"}, 32'(busy), 32'd1);
        if (v.mutate) mat_in = {(ROWS * COLS){8'd9}};
        cyc = 0;
        seen_done = 1'b0;
        while (!seen_done && cyc < 300) begin
            out_ready = v.pat[cyc % 4];
            start     = v.poke && (cyc % 3 == 1);
            @(posedge clk); #1;
            cyc++;
            if (done) seen_done = 1'b1;
        end
        start = 1'b0;
        check({v.name, "_done_seen"}, 32'(seen_done), 32'd1);
        check({v.name, "_done_valid"}, 32'(out_valid), 32'd0);
        check({v.name, "_done_busy"}, 32'(busy), 32'd1);
        check({v.name, "_beats"}, 32'(beats), 32'(v.exp_beats));
        check({v.name, "_sum"}, 32'(sum), 32'(v.exp_sum));
        check({v.name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
        check({v.name, "_done_pulse"}, 32'(done), 32'd0);
        check({v.name, "_idle_busy"}, 32'(busy), 32'd0);
        mat_in = mat_ref;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int wait_cyc;
        vecs[0] = '{name: "full_rate",  pat: 4'b1111, mutate: 1'b0, poke: 1'b0, exp_beats: 25, exp_sum: 75};
        vecs[1] = '{name: "backpress",  pat: 4'b1001, mutate: 1'b0, poke: 1'b0, exp_beats: 25, exp_sum: 75};
        vecs[2] = '{name: "isolation",  pat: 4'b1111, mutate: 1'b1, poke: 1'b1, exp_beats: 25, exp_sum: 75};
        vecs[3] = '{name: "alt_ready",  pat: 4'b0101, mutate: 1'b1, poke: 1'b1, exp_beats: 25, exp_sum: 75};

        // Element (r,c) = c+1, shifted in so that (0,0) ends at the MSB.
        mat_ref = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                mat_ref = {mat_ref[MAT_LEN-ELEM_W-1:0], ELEM_W'(c + 1)};

        rst = 1'b0; start = 1'b0; out_ready = 1'b0; mat_in = mat_ref;
        start1 = 1'b0; ready1 = 1'b0; mat1 = 8'hA5;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_row", 32'(out_row), 32'd0);
        check("rst_col", 32'(out_col), 32'd0);
        check("rst1_last", 32'(last1), 32'd0);
        check("rst1_data", 32'(data1), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) begin
            run_stream(vecs[i]);
            @(posedge clk); #1;
        end

        // Reset mid-stream after beat 10, then restart from (0,0).
        beats = 0;
        sum   = 0;
        push_expected();
        out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_cyc = 0;
        while (beats < 10 && wait_cyc < 100) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("midrst_reached_10", 32'(beats >= 10), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_data", 32'(out_data), 32'd0);
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("midrst_no_done", 32'(done), 32'd0);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check("after_rst_idle", 32'(busy), 32'd0);
        run_stream(vecs[0]);

        // Degenerate 1x1 instance: single beat flagged last, then done.
        ready1 = 1'b1;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        mat1 = 8'h3C;
        check("one_valid", 32'(valid1), 32'd1);
        check("one_data", 32'(data1), 32'hA5);
        check("one_last", 32'(last1), 32'd1);
        check("one_row", 32'(row1), 32'd0);
        check("one_col", 32'(col1), 32'd0);
        @(posedge clk); #1;
        check("one_done", 32'(done1), 32'd1);
        check("one_done_valid", 32'(valid1), 32'd0);
        check("one_done_busy", 32'(busy1), 32'd1);
        @(posedge clk); #1;
        check("one_done_pulse", 32'(done1), 32'd0);
        check("one_idle_busy", 32'(busy1), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
